qnigma_fifo_rd_stream: RTL and testbench

Read-side drain stage placed directly downstream of the dual-clock Gray-code FIFO, in the FIFO's read clock domain. It issues FIFO reads, absorbs the FIFO's one-cycle read latency in a two-entry buffer, and presents a valid/ready stream to the consumer. Sustained throughput is one word per clock with no bubbles while the FIFO is non-empty and the consumer is ready.

---
 rtl/qnigma_pkg.sv | 9 +
 rtl/qnigma_fifo_rd_stream_buf.sv | 52 +++++
 rtl/qnigma_fifo_rd_stream.sv | 78 +++++++
 tb/tb_qnigma_fifo_rd_stream.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qnigma_pkg.sv
// Shared constants and types for the qnigma FIFO read-side stream stage.
package qnigma_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = 32;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/qnigma_fifo_rd_stream_buf.sv
// Two-entry circular buffer that absorbs FIFO read latency; head entry drives the stream.
import qnigma_pkg::*;

module qnigma_fifo_rd_stream_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // A push into a full buffer is dropped defensively; the read-issue rule never allows it.
    assign push_ok = push & (occ != occ_t'(BUF_DEPTH));
    assign pop_ok  = pop & (occ != occ_t'(0));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            occ    <= occ + occ_t'(push_ok) - occ_t'(pop_ok);
            wr_ptr <= wr_ptr ^ push_ok;
            rd_ptr <= rd_ptr ^ pop_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (occ != occ_t'(0));

endmodule

// File: rtl/qnigma_fifo_rd_stream.sv
// Drains the dual-clock FIFO into a valid/ready stream at one word per clock.
// Optional delivered-word counter m_count is built when QNIGMA_FIFO_RD_STREAM_CNT_EN is defined.
import qnigma_pkg::*;

module qnigma_fifo_rd_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  m_count
`endif
);

    // Handshake: a word transfers on any clock where m_valid and m_ready are both high;
    // m_data is held while m_valid is high and m_ready is low.

    occ_t       occ;
    logic       infl;
    logic       pop;
    logic       push;
    logic [2:0] pend;

    assign pop  = m_valid & m_ready;
    // Data without an outstanding read is a protocol error and is not pushed.
    assign push = fifo_valid & infl & !flush & !rst;

    // Words owned after this cycle: buffered plus in flight minus the one leaving now.
    assign pend      = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    assign fifo_read = !rst & !flush & !fifo_empty & (pend <= 3'd1);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            infl <= 1'b0;
        end else begin
            infl <= fifo_read;
        end
    end

    qnigma_fifo_rd_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .push_data  (fifo_data),
        .occ        (occ),
        .head_data  (m_data),
        .head_valid (m_valid)
    );

`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Flush does not clear the count: flushed words were never delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign m_count = cnt_q;
`endif

endmodule

// File: tb/tb_qnigma_fifo_rd_stream.sv
// Bench for qnigma_fifo_rd_stream: queue-based FIFO and stream reference model.
import qnigma_pkg::*;

module tb_qnigma_fifo_rd_stream;

    localparam int DATA_WIDTH = 32;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
    logic [CNT_WIDTH-1:0]  m_count;
`endif

    qnigma_fifo_rd_stream #(
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
        ,
        .m_count    (m_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO contents and expected stream order.
    logic [DATA_WIDTH-1:0] fifo_q[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    logic                  ret_valid;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [31:0]           exp_cnt;
    int                    n_vec;
    int                    n_fail;
    int                    cyc_no;

    // Observations of the most recent cycle, for scenario-level checks.
    logic                  g_rd;
    logic                  g_mv;
    logic                  g_pop;
    logic [DATA_WIDTH-1:0] g_md;
    int                    g_cyc;

    task automatic cyc();
        logic                  rd;
        logic                  exp_rd;
        logic                  p;
        logic                  got_word;
        logic [DATA_WIDTH-1:0] nxt_data;
        int                    pend;
        fifo_empty = (fifo_q.size() == 0);
        fifo_valid = ret_valid;
        fifo_data  = ret_valid ? ret_data : DATA_WIDTH'($urandom());
        #1;
        rd    = fifo_read;
        g_rd  = fifo_read;
        g_mv  = m_valid;
        g_md  = m_data;
        g_cyc = cyc_no;
        n_vec++;
        if (m_valid !== (exp_q.size() != 0)) begin
            n_fail++;
            $display("FAIL m_valid cyc %0d: got %b expected %b", cyc_no, m_valid, exp_q.size() != 0);
        end
        p     = (m_valid === 1'b1) && m_ready;
        g_pop = p;
        if (p) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL m_data cyc %0d: got %h expected no beat", cyc_no, m_data);
            end else begin
                if (m_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL m_data cyc %0d: got %h expected %h", cyc_no, m_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            exp_cnt = exp_cnt + 32'd1;
        end
        pend   = exp_q.size() + (ret_valid ? 1 : 0);
        exp_rd = !rst && !flush && !fifo_empty && (pend <= 1);
        n_vec++;
        if (rd !== exp_rd) begin
            n_fail++;
            $display("FAIL fifo_read cyc %0d: got %b expected %b", cyc_no, rd, exp_rd);
        end
        if (rst || flush) exp_q.delete();
        else if (ret_valid) exp_q.push_back(ret_data);
        if (rst) exp_cnt = 32'd0;
        got_word = 1'b0;
        nxt_data = '0;
        if (rd === 1'b1) begin
            if (fifo_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL fifo_underflow cyc %0d: got read expected none", cyc_no);
            end else begin
                nxt_data = fifo_q.pop_front();
                got_word = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ret_valid = got_word;
        ret_data  = nxt_data;
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
        n_vec++;
        if (m_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL m_count cyc %0d: got %0d expected %0d", cyc_no, m_count, exp_cnt);
        end
`endif
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec += 3;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_m_valid: got %b expected 0", m_valid);
        end
        if (m_data !== '0) begin
            n_fail++;
            $display("FAIL reset_m_data: got %h expected 0", m_data);
        end
        if (fifo_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo_read: got %b expected 0", fifo_read);
        end
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
        n_vec++;
        if (m_count !== '0) begin
            n_fail++;
            $display("FAIL reset_m_count: got %0d expected 0", m_count);
        end
`endif
        exp_q.delete();
        ret_valid = 1'b0;
        exp_cnt   = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_streaming();
        int first_rd, first_mv, first_pop, last_pop, pops;
        first_rd = -1; first_mv = -1; first_pop = -1; last_pop = -1; pops = 0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DATA_WIDTH'(i));
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (g_rd && first_rd < 0) first_rd = g_cyc;
            if (g_mv && first_mv < 0) first_mv = g_cyc;
            if (g_pop) begin
                if (first_pop < 0) first_pop = g_cyc;
                last_pop = g_cyc;
                pops++;
            end
        end
        n_vec += 3;
        if (first_mv - first_rd != 2) begin
            n_fail++;
            $display("FAIL stream_latency: got %0d expected 2", first_mv - first_rd);
        end
        if (pops != 8) begin
            n_fail++;
            $display("FAIL stream_beats: got %0d expected 8", pops);
        end
        if (last_pop - first_pop != 7) begin
            n_fail++;
            $display("FAIL stream_gapless: got span %0d expected 7", last_pop - first_pop);
        end
    endtask

    task automatic test_stall();
        int reads, pops, first_pop, last_pop;
        reads = 0; pops = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DATA_WIDTH'(32'h11 + i));
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (g_rd) reads++;
            if (i >= 2) begin
                n_vec++;
                if (g_md !== DATA_WIDTH'(32'h11)) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc %0d: got %h expected 11", g_cyc, g_md);
                end
            end
        end
        n_vec++;
        if (reads != 2) begin
            n_fail++;
            $display("FAIL stall_reads: got %0d expected 2", reads);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (g_pop) begin
                if (first_pop < 0) first_pop = g_cyc;
                last_pop = g_cyc;
                pops++;
            end
        end
        n_vec += 2;
        if (pops != 4) begin
            n_fail++;
            $display("FAIL stall_release_beats: got %0d expected 4", pops);
        end
        if (last_pop - first_pop != 3) begin
            n_fail++;
            $display("FAIL stall_release_gapless: got span %0d expected 3", last_pop - first_pop);
        end
    endtask

    task automatic test_empty_boundary();
        int reads, pops;
        reads = 0; pops = 0;
        fifo_q.push_back(DATA_WIDTH'(32'hA5));
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (g_rd) reads++;
            if (g_pop) pops++;
        end
        n_vec += 4;
        if (reads != 1) begin
            n_fail++;
            $display("FAIL empty_reads: got %0d expected 1", reads);
        end
        if (pops != 1) begin
            n_fail++;
            $display("FAIL empty_beats: got %0d expected 1", pops);
        end
        if (g_mv !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_m_valid_after: got %b expected 0", g_mv);
        end
        if (g_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read_after: got %b expected 0", g_rd);
        end
    endtask

    task automatic test_flush_inflight();
        int pops;
        pops = 0;
        m_ready = 1'b0;
        fifo_q.push_back(DATA_WIDTH'(32'h21));
        repeat (3) cyc();
        fifo_q.push_back(DATA_WIDTH'(32'h22));
        cyc();
        n_vec++;
        if (g_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup_read: got %b expected 1", g_rd);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        n_vec++;
        if (g_mv !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_m_valid: got %b expected 0", g_mv);
        end
        fifo_q.push_back(DATA_WIDTH'(32'h23));
        fifo_q.push_back(DATA_WIDTH'(32'h24));
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (g_pop) pops++;
        end
        n_vec++;
        if (pops != 2) begin
            n_fail++;
            $display("FAIL flush_after_beats: got %0d expected 2", pops);
        end
    endtask

    task automatic test_reset_mid();
        int pops;
        pops = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DATA_WIDTH'(32'h31 + i));
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_vec += 2;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_m_valid: got %b expected 0", m_valid);
        end
        if (m_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_m_data: got %h expected 0", m_data);
        end
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
        n_vec++;
        if (m_count !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_m_count: got %0d expected 0", m_count);
        end
`endif
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (g_pop) pops++;
        end
        n_vec++;
        if (pops != 2) begin
            n_fail++;
            $display("FAIL rst_mid_after_beats: got %0d expected 2", pops);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 40) fifo_q.push_back(DATA_WIDTH'($urandom()));
            m_ready = ($urandom_range(0, 99) < 70);
            flush   = ($urandom_range(0, 99) < 3);
            cyc();
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 400 && (fifo_q.size() != 0 || exp_q.size() != 0 || ret_valid); i++) cyc();
        n_vec++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d words left expected 0", exp_q.size() + fifo_q.size());
        end
    endtask

`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
    task automatic test_counter();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) fifo_q.push_back(DATA_WIDTH'($urandom()));
        m_ready = 1'b1;
        for (int i = 0; i < 306; i++) cyc();
        n_vec++;
        if (m_count !== 32'd300) begin
            n_fail++;
            $display("FAIL count_300: got %0d expected 300", m_count);
        end
        m_ready = 1'b0;
        fifo_q.push_back(DATA_WIDTH'(32'h77));
        repeat (3) cyc();
        force dut.cnt_q = '1;
        #1;
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        m_ready = 1'b1;
        cyc();
        n_vec++;
        if (m_count !== 32'd0) begin
            n_fail++;
            $display("FAIL count_wrap: got %h expected 0", m_count);
        end
    endtask
`endif

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        cyc_no    = 0;
        ret_valid = 1'b0;
        ret_data  = '0;
        exp_cnt   = 32'd0;
        test_reset();
        test_streaming();
        test_stall();
        test_empty_boundary();
        test_flush_inflight();
        test_reset_mid();
        test_random();
`ifdef QNIGMA_FIFO_RD_STREAM_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
